// File: rtl/half_stream_transpose.sv
// Streaming half-precision matrix transpose: accepts a WIDTH x HEIGHT matrix row-major,
// one element per beat, then emits it column-major (transposed) one element per beat.
module half_stream_transpose #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int IW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int JW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int AW    = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t        state;
  logic [IW-1:0] wi, ri, ri_nxt;
  logic [JW-1:0] wj, rj, rj_nxt;
  logic [15:0]   buffer [DEPTH];
  logic [AW-1:0] waddr, raddr_nxt;
  logic          in_hs, out_hs;
  logic          wi_end, wj_end, ri_end, rj_end;

  assign in_ready = ~rst & (state == FILL);
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;

  assign wi_end = (wi == IW'(WIDTH - 1));
  assign wj_end = (wj == JW'(HEIGHT - 1));
  assign ri_end = (ri == IW'(WIDTH - 1));
  assign rj_end = (rj == JW'(HEIGHT - 1));

  // Read order: ri is the fast index, rj the slow one.
  always_comb begin
    ri_nxt = ri + 1'b1;
    rj_nxt = rj;
    if (ri_end) begin
      ri_nxt = '0;
      rj_nxt = rj_end ? '0 : rj + 1'b1;
    end
  end

  assign waddr     = AW'(wi * HEIGHT + wj);
  assign raddr_nxt = AW'(ri_nxt * HEIGHT + rj_nxt);

  always_ff @(posedge clk) begin
    if (in_hs) buffer[waddr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      wi        <= '0;
      wj        <= '0;
      ri        <= '0;
      rj        <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 16'h0000;
      busy      <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_hs) begin
            busy <= 1'b1;
            if (wi_end && wj_end) begin
              wi        <= '0;
              wj        <= '0;
              state     <= DRAIN;
              out_valid <= 1'b1;
              out_last  <= (DEPTH == 1);
              // A 1x1 matrix is being written on this very edge, so bypass the buffer.
              out_data  <= (DEPTH == 1) ? in_data : buffer[0];
            end else if (wj_end) begin
              wj <= '0;
              wi <= wi + 1'b1;
            end else begin
              wj <= wj + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (ri_end && rj_end) begin
              ri        <= '0;
              rj        <= '0;
              state     <= FILL;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= 16'h0000;
              busy      <= 1'b0;
            end else begin
              ri       <= ri_nxt;
              rj       <= rj_nxt;
              out_data <= buffer[raddr_nxt];
              out_last <= (ri_nxt == IW'(WIDTH - 1)) && (rj_nxt == JW'(HEIGHT - 1));
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_half_stream_transpose.sv
// Bench for half_stream_transpose: a 2x3 instance checked by a vector table, directed
// sequences and random traffic against a transpose scoreboard, plus a 1x1 instance.
module tb_half_stream_transpose;

  localparam int W = 2;
  localparam int H = 3;
  localparam int N = W * H;

  typedef logic [15:0] mat_t [N];

  typedef struct {
    logic        vin;
    logic [15:0] din;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [15:0] e_od;
    logic        chk_od;
    logic        e_ol;
    logic        e_busy;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [15:0] in_data, out_data;
  logic        rst1, in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
  logic [15:0] in_data1, out_data1;

  half_stream_transpose #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  half_stream_transpose #(.WIDTH(1), .HEIGHT(1)) dut1 (
    .clk(clk), .rst(rst1), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_last(out_last1), .busy(busy1)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Downstream ready generator: 0 always, 1 pattern 1,0,0, 2 random, 3 from table.
  int   rdy_mode  = 3;
  logic tbl_ready = 1'b1;
  int   rdy_cnt   = 0;
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (rdy_cnt % 3 == 0);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = tbl_ready;
    endcase
    rdy_cnt++;
  end

  // Scoreboard: collects accepted input beats, queues the transposed stream on completion.
  logic        mon_en = 1'b0;
  logic [16:0] exp_q[$];
  logic [16:0] e;
  logic [15:0] mat [N];
  int          fill_cnt = 0;
  logic        m_busy = 1'b0, nb, expect_ov = 1'b0, after_last = 1'b0, stall_prev = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      fill_cnt   = 0;
      m_busy     = 1'b0;
      expect_ov  = 1'b0;
      after_last = 1'b0;
      stall_prev = 1'b0;
    end else if (mon_en) begin
      chk1("busy", busy, m_busy);
      if (expect_ov) chk1("fill_to_drain_latency", out_valid, 1'b1);
      if (after_last) chk1("in_ready_after_last", in_ready, 1'b1);
      if (out_valid) chk1("in_ready_in_drain", in_ready, 1'b0);
      if (stall_prev) begin
        chk("stall_data", out_data, prev_data);
        chk1("stall_last", out_last, prev_last);
      end
      expect_ov  = 1'b0;
      after_last = 1'b0;
      nb         = m_busy;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_out: got %h, no output expected at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e[15:0]);
          chk1("out_last", out_last, e[16]);
          if (e[16]) begin
            nb         = 1'b0;
            after_last = 1'b1;
          end
        end
      end
      if (in_valid && in_ready) begin
        mat[fill_cnt] = in_data;
        fill_cnt++;
        nb = 1'b1;
        if (fill_cnt == N) begin
          for (int j = 0; j < H; j++)
            for (int i = 0; i < W; i++)
              exp_q.push_back({(j == H - 1 && i == W - 1), mat[i * H + j]});
          fill_cnt  = 0;
          expect_ov = 1'b1;
        end
      end
      m_busy     = nb;
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic send_beat(input logic [15:0] d, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL in_accept_timeout: in_ready stuck at 0 for beat %h", d);
    end
    step();
  endtask

  task automatic send_mat(input mat_t m, input int max_gap);
    for (int k = 0; k < N; k++)
      send_beat(m[k], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin
      t++;
      step();
    end
    n_vec++;
    if (exp_q.size() != 0 || out_valid) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d outputs still pending", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  mat_t m1, m2, mr;
  logic [15:0] exp1 [N];
  vec_t tbl [13];

  initial begin
    m1   = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600};
    m2   = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
    exp1 = '{16'h3C00, 16'h4400, 16'h4000, 16'h4500, 16'h4200, 16'h4600};
    for (int r = 0; r < 13; r++) begin
      tbl[r].vin    = (r < 6);
      tbl[r].din    = (r < 6) ? m1[r] : 16'h0000;
      tbl[r].ordy   = 1'b1;
      tbl[r].e_irdy = (r < 6) || (r == 12);
      tbl[r].e_ov   = (r >= 6) && (r < 12);
      tbl[r].e_od   = (r >= 6 && r < 12) ? exp1[r - 6] : 16'h0000;
      tbl[r].chk_od = (r < 12);
      tbl[r].e_ol   = (r == 11);
      tbl[r].e_busy = (r >= 1) && (r < 12);
    end

    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0;
    rst1 = 1'b1; in_valid1 = 1'b0; in_data1 = 16'h0; out_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_last", out_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 16'h0000);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    rst1 = 1'b0;

    // Basic 2x3 transpose, cycle by cycle.
    for (int r = 0; r < 13; r++) begin
      in_valid  = tbl[r].vin;
      in_data   = tbl[r].din;
      tbl_ready = tbl[r].ordy;
      @(negedge clk);
      chk1($sformatf("tbl%0d_in_ready", r), in_ready, tbl[r].e_irdy);
      chk1($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].e_ov);
      if (tbl[r].chk_od) chk($sformatf("tbl%0d_out_data", r), out_data, tbl[r].e_od);
      chk1($sformatf("tbl%0d_out_last", r), out_last, tbl[r].e_ol);
      chk1($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    mon_en   = 1'b1;

    // Stalled drain.
    rdy_mode = 1;
    send_mat(m1, 0);
    in_valid = 1'b0;
    wait_idle();

    // Gaps on the input side.
    rdy_mode = 0;
    send_mat(m1, 3);
    in_valid = 1'b0;
    wait_idle();

    // Back-to-back matrices, second one held during the first drain.
    send_mat(m1, 0);
    send_mat(m2, 0);
    in_valid = 1'b0;
    wait_idle();

    // Asynchronous reset after three beats, then a clean resend.
    for (int k = 0; k < 3; k++) send_beat(m1[k], 0);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk1("midrst_in_ready", in_ready, 1'b0);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    @(posedge clk);
    #2;
    chk1("midrst_in_ready_held", in_ready, 1'b0);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk1("postrst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    send_mat(m1, 0);
    in_valid = 1'b0;
    wait_idle();

    // Random data, random gaps, random backpressure.
    rdy_mode = 2;
    repeat (20) begin
      for (int k = 0; k < N; k++) mr[k] = 16'($urandom);
      send_mat(mr, 2);
    end
    in_valid = 1'b0;
    wait_idle();
    rdy_mode = 0;

    // 1x1 instance: single element, held once under backpressure.
    in_valid1 = 1'b1;
    in_data1  = 16'h7BFF;
    @(negedge clk);
    chk1("one_in_ready", in_ready1, 1'b1);
    chk1("one_busy_idle", busy1, 1'b0);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    chk1("one_out_valid", out_valid1, 1'b1);
    chk("one_out_data", out_data1, 16'h7BFF);
    chk1("one_out_last", out_last1, 1'b1);
    chk1("one_busy", busy1, 1'b1);
    chk1("one_in_ready_drain", in_ready1, 1'b0);
    @(posedge clk);
    #1;
    out_ready1 = 1'b1;
    @(negedge clk);
    chk("one_stall_data", out_data1, 16'h7BFF);
    chk1("one_stall_last", out_last1, 1'b1);
    @(posedge clk);
    #1;
    out_ready1 = 1'b0;
    @(negedge clk);
    chk1("one_done_valid", out_valid1, 1'b0);
    chk1("one_done_in_ready", in_ready1, 1'b1);
    chk1("one_done_busy", busy1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
